// File: rtl/modem_pkg.sv
// modem_pkg: shared FSM encoding, default constants and helpers for the transmit path
package modem_pkg;
  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    FETCH,
    WAIT_RAM,
    PRESENT,
    DONE
  } tx_state_e;
  localparam logic [7:0] PREAMBLE_BYTE_DEF = 8'hAA;
  localparam int RAM_DEPTH_DEF = 1000;
  function automatic logic [9:0] clamp_len(input logic [9:0] len, input logic [9:0] depth);
    return (len > depth) ? depth : len;
  endfunction
endpackage

// File: rtl/tx_sequencer_if.sv
// tx_sequencer_if: register-block, message-RAM and modulator signals of the transmit sequencer
interface tx_sequencer_if;
  logic       i_transmit;
  logic [9:0] i_msg_length;
  logic [7:0] i_ram_data;
  logic       i_byte_ready;
  logic       o_ram_rd;
  logic [9:0] o_ram_addr;
  logic [7:0] o_byte;
  logic       o_byte_valid;
  logic       o_busy;
  logic       o_tx_done;
  modport master (
    input  i_transmit, i_msg_length, i_ram_data, i_byte_ready,
    output o_ram_rd, o_ram_addr, o_byte, o_byte_valid, o_busy, o_tx_done
  );
  modport slave (
    output i_transmit, i_msg_length, i_ram_data, i_byte_ready,
    input  o_ram_rd, o_ram_addr, o_byte, o_byte_valid, o_busy, o_tx_done
  );
endinterface

// File: rtl/tx_sequencer.sv
// tx_sequencer: sends a preamble then fetches payload bytes from message RAM to the modulator
module tx_sequencer
  import modem_pkg::*;
#(
  parameter int         PREAMBLE_LEN  = 4,
  parameter logic [7:0] PREAMBLE_BYTE = PREAMBLE_BYTE_DEF,
  parameter int         RAM_DEPTH     = RAM_DEPTH_DEF
) (
  input logic            clk,
  input logic            reset,
  tx_sequencer_if.master bus
);
  localparam logic [9:0] DEPTH    = 10'(RAM_DEPTH);
  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_LEN - 1);
  localparam bit         NO_PRE   = (PREAMBLE_LEN == 0);
  tx_state_e  state_q, state_d;
  logic [9:0] len_q, len_d;
  logic [9:0] idx_q, idx_d;
  logic [9:0] ram_addr_q, ram_addr_d;
  logic [3:0] pre_cnt_q, pre_cnt_d;
  logic [7:0] byte_q, byte_d;
  logic       tx_prev_q;
  logic       ram_rd_q, ram_rd_d;
  logic       byte_valid_q, byte_valid_d;
  logic       busy_q, busy_d;
  logic       tx_done_q, tx_done_d;
  logic       tx_rise, accept;
  assign tx_rise = bus.i_transmit & ~tx_prev_q;
  assign accept  = byte_valid_q & bus.i_byte_ready;
  // next state plus outputs derived from the next state, so every output is a flop
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    pre_cnt_d = pre_cnt_q;
    byte_d    = byte_q;
    case (state_q)
      IDLE: if (tx_rise) begin
        len_d     = clamp_len(bus.i_msg_length, DEPTH);
        idx_d     = '0;
        pre_cnt_d = '0;
        state_d   = !NO_PRE ? PREAMBLE : (len_d != '0) ? FETCH : DONE;
      end
      PREAMBLE: if (accept) begin
        pre_cnt_d = pre_cnt_q + 4'd1;
        if (pre_cnt_q == PRE_LAST) state_d = (len_q != '0) ? FETCH : DONE;
      end
      FETCH: state_d = WAIT_RAM;
      WAIT_RAM: begin
        byte_d  = bus.i_ram_data;
        state_d = PRESENT;
      end
      PRESENT: if (accept) begin
        idx_d   = idx_q + 10'd1;
        state_d = (idx_d == len_q) ? DONE : FETCH;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    byte_d       = (state_d == PREAMBLE) ? PREAMBLE_BYTE : byte_d;
    byte_valid_d = (state_d == PREAMBLE) || (state_d == PRESENT);
    ram_rd_d     = (state_d == FETCH);
    ram_addr_d   = (state_d == FETCH) ? idx_d : ram_addr_q;
    busy_d       = (state_d != IDLE);
    tx_done_d    = (state_d == DONE);
  end
  // state and output registers; reset clears everything immediately, even mid-frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      idx_q        <= '0;
      pre_cnt_q    <= '0;
      byte_q       <= '0;
      ram_addr_q   <= '0;
      tx_prev_q    <= 1'b0;
      ram_rd_q     <= 1'b0;
      byte_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      pre_cnt_q    <= pre_cnt_d;
      byte_q       <= byte_d;
      ram_addr_q   <= ram_addr_d;
      tx_prev_q    <= bus.i_transmit;
      ram_rd_q     <= ram_rd_d;
      byte_valid_q <= byte_valid_d;
      busy_q       <= busy_d;
      tx_done_q    <= tx_done_d;
    end
  end
  assign bus.o_ram_rd     = ram_rd_q;
  assign bus.o_ram_addr   = ram_addr_q;
  assign bus.o_byte       = byte_q;
  assign bus.o_byte_valid = byte_valid_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_tx_done    = tx_done_q;
endmodule

// File: tb/tb_tx_sequencer.sv
// tb_tx_sequencer: directed frames against a synchronous RAM model and a transfer monitor
module tb_tx_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  tx_sequencer_if bus();
  tx_sequencer #(.PREAMBLE_LEN(4), .PREAMBLE_BYTE(8'hAA), .RAM_DEPTH(1000)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [7:0] acc[$];
  int acc_t[$];
  int rd[$];
  function automatic logic [7:0] ram_val(input logic [9:0] a);
    return 8'((int'(a) + 1) * 17);
  endfunction
  // synchronous RAM: data appears the cycle after the read strobe
  always @(posedge clk) if (bus.o_ram_rd) bus.i_ram_data <= ram_val(bus.o_ram_addr);
  // record accepted bytes, RAM reads and done pulses mid-cycle
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.o_byte_valid && bus.i_byte_ready) begin
      acc.push_back(bus.o_byte);
      acc_t.push_back(cyc);
    end
    if (bus.o_ram_rd) rd.push_back(int'(bus.o_ram_addr));
    if (bus.o_tx_done) done_cnt <= done_cnt + 1;
  end
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    acc.delete();
    acc_t.delete();
    rd.delete();
    done_cnt = 0;
  endtask
  task automatic start(input logic [9:0] l);
    clear();
    bus.i_msg_length = l;
    bus.i_transmit = 1'b1;
    tick();
    bus.i_transmit = 1'b0;
  endtask
  task automatic wait_done(input int max);
    for (int i = 0; i < max && done_cnt == 0; i++) begin
      @(negedge clk);
      #1;
    end
    repeat (3) begin
      @(negedge clk);
      #1;
    end
    check("done_pulses", done_cnt, 1);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_rd"}, int'(bus.o_ram_rd), 0);
    check({tag, "_addr"}, int'(bus.o_ram_addr), 0);
    check({tag, "_byte"}, int'(bus.o_byte), 0);
    check({tag, "_valid"}, int'(bus.o_byte_valid), 0);
    check({tag, "_busy"}, int'(bus.o_busy), 0);
    check({tag, "_done"}, int'(bus.o_tx_done), 0);
  endtask
  initial begin
    logic [7:0] exp_n[7];
    exp_n = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'h11, 8'h22, 8'h33};
    reset = 1'b1;
    bus.i_transmit = 1'b0;
    bus.i_msg_length = '0;
    bus.i_byte_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    tick();
    reset = 1'b0;
    repeat (2) tick();
    start(10'd3);
    wait_done(200);
    check("n_count", acc.size(), 7);
    for (int i = 0; i < 7; i++) check($sformatf("n_byte%0d", i), int'(acc[i]), int'(exp_n[i]));
    check("n_reads", rd.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("n_addr%0d", i), rd[i], i);
    check("n_rate", acc_t[5] - acc_t[4], 3);
    check("n_idle", int'(bus.o_busy), 0);
    start(10'd0);
    wait_done(200);
    check("z_count", acc.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("z_byte%0d", i), int'(acc[i]), 8'hAA);
    check("z_reads", rd.size(), 0);
    start(10'd3);
    for (int i = 0; i < 200 && acc.size() < 5; i++) begin
      @(negedge clk);
      #1;
    end
    tick();
    bus.i_byte_ready = 1'b0;
    for (int i = 0; i < 10 && !bus.o_byte_valid; i++) begin
      @(negedge clk);
      #1;
    end
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid%0d", k), int'(bus.o_byte_valid), 1);
      check($sformatf("bp_byte%0d", k), int'(bus.o_byte), 8'h22);
      if (k < 4) begin
        @(negedge clk);
        #1;
      end
    end
    tick();
    bus.i_byte_ready = 1'b1;
    wait_done(200);
    check("bp_count", acc.size(), 7);
    check("bp_b5", int'(acc[5]), 8'h22);
    check("bp_b6", int'(acc[6]), 8'h33);
    check("bp_reads", rd.size(), 3);
    start(10'd1023);
    wait_done(5000);
    check("c_count", acc.size(), 1004);
    check("c_reads", rd.size(), 1000);
    check("c_first_addr", rd[0], 0);
    check("c_last_addr", rd[999], 999);
    check("c_last_byte", int'(acc[1003]), 8'h68);
    clear();
    bus.i_msg_length = 10'd2;
    bus.i_transmit = 1'b1;
    wait_done(200);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("h_held%0d", k), int'(bus.o_busy), 0);
      @(negedge clk);
      #1;
    end
    check("h_count", acc.size(), 6);
    tick();
    bus.i_transmit = 1'b0;
    tick();
    clear();
    bus.i_transmit = 1'b1;
    for (int i = 0; i < 4 && !bus.o_busy; i++) begin
      @(negedge clk);
      #1;
    end
    check("h_restart", int'(bus.o_busy), 1);
    wait_done(200);
    check("h_count2", acc.size(), 6);
    tick();
    bus.i_transmit = 1'b0;
    tick();
    start(10'd3);
    for (int i = 0; i < 200 && rd.size() < 3; i++) begin
      @(negedge clk);
      #1;
    end
    check("r_at_addr2", int'(bus.o_ram_addr), 2);
    #1;
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    tick();
    tick();
    reset = 1'b0;
    clear();
    repeat (10) tick();
    check("r_no_resume_busy", int'(bus.o_busy), 0);
    check("r_no_resume_bytes", acc.size(), 0);
    check("r_no_resume_reads", rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
